// File: rtl/board_input_cond_pkg.sv
// +----------------------------------------------------------------------------+
// | Package   : agat_io_pkg                                                    |
// | Purpose   : Shared constants and helpers for the Agat board input path:    |
// |             default debounce lengths, encoder direction encoding and a     |
// |             ceiling-log2 helper for sizing counters.                       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package agat_io_pkg;

  // 1 ms at 50 MHz for mechanical push-buttons
  localparam int DEB_1MS_50M = 50000;
  // Quadrature contacts bounce far less than push-buttons
  localparam int DEB_ROT     = 500;

  // Encoder direction encoding as seen on rot_dir
  localparam logic ROT_CW  = 1'b1;
  localparam logic ROT_CCW = 1'b0;

  // Smallest r with 2**r >= value; returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_input_cond_if.sv
// +----------------------------------------------------------------------------+
// | Interface : board_input_cond_if                                            |
// | Purpose   : Bundles raw board pins and conditioned outputs of the input    |
// |             conditioner. slave = conditioner side, master = pin/consumer   |
// |             side.                                                          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface board_input_cond_if #(
  parameter int NUM_BTN = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               rot_a;
  logic               rot_b;
  logic               rot_center;
  logic               rot_press;
  logic               rot_step;
  logic               rot_dir;
  logic               pos_clr;
  logic [CNT_W-1:0]   rot_pos;

  modport master (
    output btn_raw, rot_a, rot_b, rot_center, pos_clr,
    input  btn_level, btn_press, btn_release, rot_press, rot_step, rot_dir, rot_pos
  );

  modport slave (
    input  btn_raw, rot_a, rot_b, rot_center, pos_clr,
    output btn_level, btn_press, btn_release, rot_press, rot_step, rot_dir, rot_pos
  );
endinterface

`default_nettype wire

// File: rtl/board_input_cond_debounce.sv
// +----------------------------------------------------------------------------+
// | Module    : input_debounce                                                 |
// | Purpose   : One input channel: 2-FF synchroniser, stability counter,       |
// |             debounced level and one-cycle rise/fall pulses. The pulse is   |
// |             produced together with the level update, so both appear        |
// |             2 + DEB cycles after the raw edge. DEB must be >= 2.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module input_debounce
  import agat_io_pkg::*;
#(
  parameter int DEB = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW      = (clog2(DEB) > 0) ? clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next counter value while the synced input disagrees with the stable level
  always_comb begin
    cnt_d = cnt_q + CW'(1);
  end

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept the new level after DEB consecutive disagreeing samples; any agreeing sample restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        rise_q   <= sync2_q;
        fall_q   <= ~sync2_q;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/board_input_cond.sv
// +----------------------------------------------------------------------------+
// | Module    : board_input_cond                                               |
// | Purpose   : Board-level input conditioner. Debounces NUM_BTN push-buttons  |
// |             and the encoder centre push, and decodes the quadrature        |
// |             encoder into step pulses, direction and a wrapping signed      |
// |             position.                                                      |
// | Config    : ROTARY_DECODE_EN - when defined the rotary decoder is built;   |
// |             otherwise rot_step/rot_dir/rot_pos are tied to zero.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module board_input_cond
  import agat_io_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int DEB_CYCLES     = DEB_1MS_50M,
  parameter int ROT_DEB_CYCLES = DEB_ROT,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  board_input_cond_if.slave    bus
);

  logic [NUM_BTN-1:0] btn_level_w;
  logic [NUM_BTN-1:0] btn_press_w;
  logic [NUM_BTN-1:0] btn_release_w;
  logic               center_level_w;
  logic               center_fall_w;
  logic               unused_sink_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    input_debounce #(.DEB(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (bus.btn_raw[i]),
      .level_o (btn_level_w[i]),
      .rise_o  (btn_press_w[i]),
      .fall_o  (btn_release_w[i])
    );
  end

  // Encoder centre push behaves like one more button channel
  input_debounce #(.DEB(DEB_CYCLES)) u_deb_center (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.rot_center),
    .level_o (center_level_w),
    .rise_o  (bus.rot_press),
    .fall_o  (center_fall_w)
  );

  assign bus.btn_level   = btn_level_w;
  assign bus.btn_press   = btn_press_w;
  assign bus.btn_release = btn_release_w;

`ifdef ROTARY_DECODE_EN
  logic             a_level_w;
  logic             a_rise_w;
  logic             a_fall_w;
  logic             b_level_w;
  logic             b_rise_w;
  logic             b_fall_w;
  logic             rot_step_q;
  logic             rot_dir_q;
  logic [CNT_W-1:0] rot_pos_q;
  logic [CNT_W-1:0] rot_pos_d;
  logic             dir_w;

  input_debounce #(.DEB(ROT_DEB_CYCLES)) u_deb_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.rot_a),
    .level_o (a_level_w),
    .rise_o  (a_rise_w),
    .fall_o  (a_fall_w)
  );

  input_debounce #(.DEB(ROT_DEB_CYCLES)) u_deb_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.rot_b),
    .level_o (b_level_w),
    .rise_o  (b_rise_w),
    .fall_o  (b_fall_w)
  );

  // B low at the A rising edge means clockwise
  assign dir_w = b_level_w ? ROT_CCW : ROT_CW;

  // Position update: clear has priority, otherwise step by +/-1 with natural wrap
  always_comb begin
    rot_pos_d = rot_pos_q;
    if (bus.pos_clr) begin
      rot_pos_d = '0;
    end else if (a_rise_w) begin
      rot_pos_d = (dir_w == ROT_CW) ? rot_pos_q + CNT_W'(1) : rot_pos_q - CNT_W'(1);
    end
  end

  // One step per detent, taken on the debounced A rising edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_step_q <= 1'b0;
      rot_dir_q  <= 1'b0;
      rot_pos_q  <= '0;
    end else begin
      rot_step_q <= a_rise_w;
      if (a_rise_w) rot_dir_q <= dir_w;
      rot_pos_q <= rot_pos_d;
    end
  end

  assign bus.rot_step = rot_step_q;
  assign bus.rot_dir  = rot_dir_q;
  assign bus.rot_pos  = rot_pos_q;
  assign unused_sink_w = ^{center_level_w, center_fall_w, a_level_w, a_fall_w, b_rise_w, b_fall_w};
`else
  assign bus.rot_step  = 1'b0;
  assign bus.rot_dir   = 1'b0;
  assign bus.rot_pos   = '0;
  assign unused_sink_w = ^{center_level_w, center_fall_w, bus.rot_a, bus.rot_b, bus.pos_clr};
`endif

endmodule

`default_nettype wire
